// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the latch-trigger pipeline controllers.
package pipe_ctrl_pkg;

  localparam int STAGES_DEF = 4;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 16;
  localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/pipe_lt_cell.sv
// One pipeline stage: fires when its source is valid and it is empty or draining.
// Latency: lt/occ one cycle after fire; backpressure arrives through move.
module pipe_lt_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic src_valid,
  input  logic move,
  output logic fire,
  output logic occ,
  output logic lt
);

  assign fire = src_valid & (~occ | move);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= 1'b0;
      lt  <= 1'b0;
    end else begin
      occ <= fire | (occ & ~move);
      lt  <= fire;
    end
  end

endmodule

// File: rtl/pipe_lt_ctrl.sv
// Latch-trigger sequencer for a STAGES-deep pipeline; latency STAGES cycles, 1 op/cycle.
// Full with out_ack low holds all state; optional stall counter under PIPE_LT_CTRL_STALL_CNT_EN.
module pipe_lt_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_req,
  output logic              in_ack,
  output logic [STAGES-1:0] lt,
  output logic              out_req,
  input  logic              out_ack,
  output logic [STAGES-1:0] occ
`ifdef PIPE_LT_CTRL_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt
`endif
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX || CNT_W < 1) begin : g_bad_cfg
    $error("pipe_lt_ctrl: STAGES or CNT_W out of range");
  end

  // Blocks stage 0 on the first edge after reset release, so no lt edge
  // can appear before the second clk edge.
  logic armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // move resolves from the output end backward through each stage's fire.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic src_valid_w;
    logic move_w;
    logic fire_w;

    if (i == 0) begin : g_head
      assign src_valid_w = in_req & armed;
    end else begin : g_body
      assign src_valid_w = occ[i-1];
    end

    if (i == STAGES-1) begin : g_tail
      assign move_w = out_ack;
    end else begin : g_link
      assign move_w = g_stage[i+1].fire_w;
    end

    pipe_lt_cell u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_valid (src_valid_w),
      .move      (move_w),
      .fire      (fire_w),
      .occ       (occ[i]),
      .lt        (lt[i])
    );
  end

  assign in_ack  = lt[0];
  assign out_req = occ[STAGES-1];

`ifdef PIPE_LT_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_req && !out_ack && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_lt_ctrl.sv
// Directed bench for pipe_lt_ctrl (STAGES=4); stall checks active when PIPE_LT_CTRL_STALL_CNT_EN is defined.
module tb_pipe_lt_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_req;
  logic       in_ack;
  logic [3:0] lt;
  logic       out_req;
  logic       out_ack;
  logic [3:0] occ;
`ifdef PIPE_LT_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_lt_ctrl #(.STAGES(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_req    (in_req),
    .in_ack    (in_ack),
    .lt        (lt),
    .out_req   (out_req),
    .out_ack   (out_ack),
    .occ       (occ)
`ifdef PIPE_LT_CTRL_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic [31:0] exp);
`ifdef PIPE_LT_CTRL_STALL_CNT_EN
    chk(tag, {16'd0, stall_cnt}, exp);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    in_req  = 1'b0;
    out_ack = 1'b0;
    #2;
    chk("rst_occ", occ, 4'b0000);
    chk("rst_lt", lt, 4'b0000);
    chk("rst_out_req", out_req, 1'b0);
    chk("rst_in_ack", in_ack, 1'b0);
    chk_stall("rst_stall", 0);
    #1 rst_n = 1'b1;
    tick();
    tick();

    // Single operand walks through with out_ack high.
    in_req  = 1'b1;
    out_ack = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      in_req = 1'b0;
      chk($sformatf("single_lt_%0d", k), lt, (k <= 4) ? (4'b0001 << (k-1)) : 4'b0000);
      chk($sformatf("single_out_req_%0d", k), out_req, (k == 4));
      if (k == 1) chk("single_in_ack", in_ack, 1'b1);
    end

    // Eight back-to-back operands.
    in_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 8) in_req = 1'b0;
      chk($sformatf("stream_in_ack_%0d", k), in_ack, (k <= 8));
      chk($sformatf("stream_out_req_%0d", k), out_req, (k >= 4 && k <= 11));
    end

    // Fill against a stalled output.
    out_ack = 1'b0;
    in_req  = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("fill_in_ack_%0d", k), in_ack, (k <= 4));
      chk($sformatf("fill_occ_%0d", k), occ, (k <= 4) ? ((4'b0001 << k) - 4'b0001) : 4'b1111);
      if (k >= 5) begin
        chk($sformatf("fill_lt_%0d", k), lt, 4'b0000);
        chk_stall($sformatf("fill_stall_%0d", k), k - 4);
      end
    end

    // Full pipe: consume and accept in the same cycle.
    out_ack = 1'b1;
    tick();
    chk("full_move_lt", lt, 4'b1111);
    chk("full_move_occ", occ, 4'b1111);
    chk("full_move_in_ack", in_ack, 1'b1);
    chk_stall("full_move_stall", 3);

    // Reset mid-operation with in_req still high.
    out_ack = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("rst2_occ", occ, 4'b0000);
    chk("rst2_lt", lt, 4'b0000);
    chk("rst2_out_req", out_req, 1'b0);
    chk_stall("rst2_stall", 0);
    #1 rst_n = 1'b1;
    tick();
    chk("arm_first_edge_lt", lt, 4'b0000);
    chk("arm_first_edge_occ", occ, 4'b0000);
    tick();
    chk("arm_second_edge_lt", lt, 4'b0001);
    chk("arm_second_edge_in_ack", in_ack, 1'b1);

    // Build occ = 0101 with out_ack low.
    in_req = 1'b0;
    tick();
    chk("bub_occ_0010", occ, 4'b0010);
    in_req = 1'b1;
    tick();
    chk("bub_occ_0101", occ, 4'b0101);
    chk("bub_lt_0101", lt, 4'b0101);

    // Stage 0 advances into stage 1; stage 2 also advances into empty stage 3.
    in_req = 1'b0;
    tick();
    chk("bub_lt1", lt[1], 1'b1);
    chk("bub_lt", lt, 4'b1010);
    chk("bub_occ", occ, 4'b1010);
    tick();
    chk("bub_occ_1100", occ, 4'b1100);
    in_req = 1'b1;
    tick();
    chk("bub_occ_1101", occ, 4'b1101);
    out_ack = 1'b1;
    tick();
    chk("bub_occ_1011", occ, 4'b1011);
    chk("bub_lt_1011", lt, 4'b1011);
    chk_stall("bub_stall", 2);

    // Asynchronous reset from occ = 1011, then idle.
    in_req  = 1'b0;
    out_ack = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("rst3_occ", occ, 4'b0000);
    chk("rst3_lt", lt, 4'b0000);
    chk("rst3_out_req", out_req, 1'b0);
    chk("rst3_in_ack", in_ack, 1'b0);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("idle_lt_%0d", k), lt, 4'b0000);
      chk($sformatf("idle_occ_%0d", k), occ, 4'b0000);
    end
    in_req = 1'b1;
    tick();
    chk("restart_lt", lt, 4'b0001);
    chk("restart_occ", occ, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
